// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: write-side controller for the 32x32 register file.
// Arbitrates the ALU result (highest priority, never stalled) against buffered
// LSU results. It drives the register-file write port from flops and keeps a
// per-register pending-write scoreboard for the issue stage.
// Ports:
//   clk, reset            clock; synchronous active-low reset
//   issue_valid/issue_rd  destination issued this cycle (sets busy)
//   alu_valid/rd/data     single-cycle ALU writeback request
//   lsu_valid/rd/data     LSU result offer; lsu_ready = FIFO not full
//   wb_addr/data/enable   registered register-file write port
//   busy_mask             registered pending-write scoreboard (bit 0 always 0)
//   lsu_count             LSU FIFO occupancy
module regfile_wb_ctrl #(
  parameter int unsigned LSU_DEPTH = 4,
  parameter int unsigned CNT_W     = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rd,
  input  logic             alu_valid,
  input  logic [4:0]       alu_rd,
  input  logic [31:0]      alu_data,
  input  logic             lsu_valid,
  output logic             lsu_ready,
  input  logic [4:0]       lsu_rd,
  input  logic [31:0]      lsu_data,
  output logic [4:0]       wb_addr,
  output logic [31:0]      wb_data,
  output logic             wb_enable,
  output logic [31:0]      busy_mask,
  output logic [CNT_W-1:0] lsu_count
);

  localparam int unsigned PTR_W  = (LSU_DEPTH > 1) ? $clog2(LSU_DEPTH) : 1;
  localparam int unsigned RD_W   = 5;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  wb_entry_t         fifo_q [LSU_DEPTH];
  wb_entry_t         fifo_d [LSU_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              wb_enable_q, wb_enable_d;
  logic [RD_W-1:0]   wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [31:0]       busy_q, busy_d;

  logic              push;
  logic              pop;
  logic              sel_valid;
  wb_entry_t         sel;

  // Ready depends only on the registered occupancy, never on lsu_valid.
  assign lsu_ready = (count_q != CNT_W'(LSU_DEPTH));

  // Arbitration, FIFO bookkeeping, writeback and scoreboard next state.
  always_comb begin
    push      = lsu_valid && lsu_ready;
    pop       = !alu_valid && (count_q != '0);
    sel_valid = alu_valid || pop;
    sel       = alu_valid ? wb_entry_t'{rd: alu_rd, data: alu_data} : fifo_q[rd_ptr_q];

    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q] = wb_entry_t'{rd: lsu_rd, data: lsu_data};
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    // Idle cycles hold addr/data so the port only toggles on real traffic.
    wb_enable_d = sel_valid && (sel.rd != '0);
    wb_addr_d   = sel_valid ? sel.rd   : wb_addr_q;
    wb_data_d   = sel_valid ? sel.data : wb_data_q;

    // Clear on the commit currently on the port; a same-edge issue wins.
    busy_d = busy_q;
    if (wb_enable_q) begin
      busy_d[wb_addr_q] = 1'b0;
    end
    if (issue_valid) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(LSU_DEPTH); i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wb_enable_q <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      busy_q      <= '0;
    end else begin
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wb_enable_q <= wb_enable_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      busy_q      <= busy_d;
    end
  end

  assign wb_enable = wb_enable_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
  assign busy_mask = busy_q;
  assign lsu_count = count_q;

endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
Write-side controller for the 32x32 register file: arbitrates writeback from the single-cycle ALU and the multi-cycle load/store unit. It drives the register file write port (wb_addr/wb_data/wb_enable) from registered outputs. It buffers LSU results in a small FIFO and keeps a per-register pending (busy) scoreboard for the issue stage's hazard check.

Parameters:
LSU_DEPTH, 4, LSU result FIFO entries (power of 2, >=2)
CNT_W, 3, width of lsu_count (must hold 0..LSU_DEPTH)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset
issue_valid  input  1  instruction with a destination issued this cycle
issue_rd  input  5  destination register of issued instruction
alu_valid  input  1  ALU result valid; never back-pressured
alu_rd  input  5  ALU destination register
alu_data  input  32  ALU result
lsu_valid  input  1  LSU result offered
lsu_ready  output  1  FIFO can accept (combinational: not full)
lsu_rd  input  5  LSU destination register
lsu_data  input  32  LSU load data
wb_addr  output  5  register file write_addr (registered)
wb_data  output  32  register file write_data (registered)
wb_enable  output  1  register file write_enable (registered)
busy_mask  output  32  bit r = 1: write to xr pending (registered)
lsu_count  output  CNT_W  current FIFO occupancy

Behaviour:
- Reset (reset==0 at an edge): wb_enable=0, wb_addr=0, wb_data=0, busy_mask=0, FIFO emptied (lsu_count=0). Reset overrides all same-cycle inputs. In-flight FIFO data is discarded.
- The block uses one clock and synchronous active-low reset.
- LSU accept: at an edge with lsu_valid && lsu_ready, push {lsu_rd, lsu_data}. lsu_ready = (lsu_count != LSU_DEPTH). It does not depend on lsu_valid.
- Arbitration per cycle (fixed priority):
  1. alu_valid: the ALU result is selected.
  2. Otherwise, if the FIFO is non-empty, the FIFO head is selected and popped at this edge.
  3. Otherwise nothing is selected.
- Registration: at the edge, wb_addr/wb_data take the selected rd/data. wb_enable = selected && rd != 0.
  - When nothing is selected, wb_enable=0 and wb_addr/wb_data hold their previous values.
- Latency: ALU result at edge N appears on wb_* after edge N, and the register file captures it at edge N+1.
  - An LSU result pushed at edge N is popped earliest at edge N+1 and appears on wb_* after edge N+1.
- x0 writes: a selected entry with rd==0 is consumed (FIFO popped) but wb_enable stays 0. busy_mask[0] is constant 0.
- Simultaneous push and pop on the same edge: occupancy is unchanged. A push is allowed when full only if a pop occurs the same edge? No: lsu_ready uses the pre-edge count, so a full FIFO never pushes.
- FIFO pointers wrap modulo LSU_DEPTH. Order is strict FIFO.
- ALU starvation of the LSU path is permitted. While the FIFO is full, lsu_ready=0 until a non-ALU cycle pops.
- Scoreboard, per register r!=0, at each edge:
  - set if issue_valid && issue_rd==r;
  - else clear if wb_enable && wb_addr==r (the same edge the register file commits).
  - Set wins over clear on the same register.
  - Multiple outstanding writes to one register are not tracked: busy clears on the first commit. The issue stage must stall on busy.
- No combinational path from lsu_valid to lsu_ready. wb_* have no combinational path from inputs.

Test Plan:
1. Reset hold then release -> wb_enable=0, busy_mask=0, lsu_count=0, lsu_ready=1. Reassert reset mid-stream with 2 FIFO entries -> all cleared next edge, entries never written.
2. issue x5 at edge 0; alu_valid rd=5 data=0xDEADBEEF at edge 1 -> wb_enable=1, wb_addr=5, wb_data=0xDEADBEEF after edge 1; busy_mask[5] 1 after edge 0, 0 after edge 2.
3. alu_valid held every cycle while LSU pushes rd=1..5 data=0x11..0x55 -> lsu_ready drops after 4 accepts, lsu_count=4. Drop alu_valid -> writes x1..x4 in order, one per cycle, then x5 accepted and written.
4. Same edge: LSU push rd=7 with empty FIFO and alu_valid rd=3 -> x3 written first, x7 the following cycle. Occupancy goes 0->1->0.
5. alu_valid rd=0 data=0xFFFFFFFF, and LSU entry rd=0 -> wb_enable stays 0, FIFO pops, busy_mask[0]=0 throughout.
6. Same edge: issue_valid rd=9 while wb commits x9 -> busy_mask[9]=1 afterwards (set wins).
